// File: rtl/run_controller_if.sv
// ---------------------------------------------------------------------------
// run_controller_if
// Groups the run controller's control inputs and status outputs.
//   restart    : request to re-run the reset/run sequence
//   step_mode  : 1 = single-step, 0 = free run (level)
//   step_req   : step button, acts on its rising edge
//   halt_req   : halt level from the CPU
//   cpu_rst    : active-low CPU reset
//   cpu_en     : CPU clock enable
//   cycle_count: enabled cycles since last reset/restart
//   done       : controller is in DONE
//   halt_cause : 00 none, 01 halt_req, 10 cycle limit
//   state      : current FSM encoding
// master drives the controls (test/host side); slave is the controller.
// ---------------------------------------------------------------------------
interface run_controller_if #(
    parameter int CNT_W = 32
);
    logic             restart;
    logic             step_mode;
    logic             step_req;
    logic             halt_req;
    logic             cpu_rst;
    logic             cpu_en;
    logic [CNT_W-1:0] cycle_count;
    logic             done;
    logic [1:0]       halt_cause;
    logic [2:0]       state;

    modport master (
        output restart, step_mode, step_req, halt_req,
        input  cpu_rst, cpu_en, cycle_count, done, halt_cause, state
    );

    modport slave (
        input  restart, step_mode, step_req, halt_req,
        output cpu_rst, cpu_en, cycle_count, done, halt_cause, state
    );
endinterface

// File: rtl/run_controller.sv
// ---------------------------------------------------------------------------
// run_controller
// Sequences a CPU through a reset hold, then free-run or single-step
// execution, and stops it on a halt request or after MAX_CYCLES enabled
// cycles. All outputs come straight from flops.
//   clk : system clock, rising edge
//   rst : synchronous active-low reset
//   bus : run_controller_if.slave (controls in, status out)
// Parameters: RST_CYCLES (1..255) hold length, MAX_CYCLES (0 = unlimited),
// CNT_W cycle counter width.
// ---------------------------------------------------------------------------
module run_controller #(
    parameter int RST_CYCLES = 6,
    parameter int MAX_CYCLES = 50,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    run_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        RUN        = 3'd1,
        STEP_WAIT  = 3'd2,
        STEP_EXEC  = 3'd3,
        DONE       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [7:0]       hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       cause_q, cause_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             cpu_en_q, cpu_en_d;
    logic             done_q, done_d;
    logic             step_prev_q;
    logic             step_edge;
    logic             limit_hit;

    always_comb begin
        step_edge = bus.step_req & ~step_prev_q;
        // Saturating increment; compared at 64 bits so a MAX_CYCLES beyond
        // the counter range can never alias onto a truncated value.
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        limit_hit = (MAX_CYCLES != 0) && (64'(cnt_inc) == 64'(MAX_CYCLES));

        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        // The edge that ends an enabled cycle always counts, even when it
        // also stops the CPU.
        if (cpu_en_q) cnt_d = cnt_inc;

        if (bus.restart) begin
            state_d = RESET_HOLD;
            hold_d  = '0;
            cnt_d   = '0;
            cause_d = 2'b00;
        end else if (cpu_en_q && bus.halt_req) begin
            state_d = DONE;
            cause_d = 2'b01;
        end else if (cpu_en_q && limit_hit) begin
            state_d = DONE;
            cause_d = 2'b10;
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    if (hold_q == 8'(RST_CYCLES - 1)) begin
                        hold_d  = '0;
                        state_d = bus.step_mode ? STEP_WAIT : RUN;
                    end else begin
                        hold_d = hold_q + 8'd1;
                    end
                end
                RUN:       if (bus.step_mode) state_d = STEP_WAIT;
                // Leaving step mode takes priority over a coincident step.
                STEP_WAIT: begin
                    if (!bus.step_mode)  state_d = RUN;
                    else if (step_edge)  state_d = STEP_EXEC;
                end
                STEP_EXEC: state_d = STEP_WAIT;
                DONE:      state_d = DONE;
                default: begin
                    state_d = RESET_HOLD;
                    hold_d  = '0;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with
        // the state they describe.
        cpu_rst_d = (state_d != RESET_HOLD);
        cpu_en_d  = (state_d == RUN) || (state_d == STEP_EXEC);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RESET_HOLD;
            hold_q      <= '0;
            cnt_q       <= '0;
            cause_q     <= 2'b00;
            cpu_rst_q   <= 1'b0;
            cpu_en_q    <= 1'b0;
            done_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            cpu_rst_q   <= cpu_rst_d;
            cpu_en_q    <= cpu_en_d;
            done_q      <= done_d;
            step_prev_q <= bus.step_req;
        end
    end

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.cpu_en      = cpu_en_q;
    assign bus.cycle_count = cnt_q;
    assign bus.done        = done_q;
    assign bus.halt_cause  = cause_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_run_controller.sv
// ---------------------------------------------------------------------------
// tb_run_controller
// Two controllers: dut1 (RST_CYCLES=6, MAX_CYCLES=50, CNT_W=32) and dut2
// (MAX_CYCLES=0, CNT_W=4). A behavioural model tracks both and is compared
// after every clock edge; directed table rows and sequences add explicit
// checks of the corner cases.
// ---------------------------------------------------------------------------
module tb_run_controller;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    run_controller_if #(.CNT_W(32)) if1 ();
    run_controller_if #(.CNT_W(4))  if2 ();

    run_controller #(.RST_CYCLES(6), .MAX_CYCLES(50), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst_n), .bus(if1));
    run_controller #(.RST_CYCLES(6), .MAX_CYCLES(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst_n), .bus(if2));

    int n_vec = 0;
    int n_err = 0;

    // Behavioural view: cycles of reset hold left, and which activity the
    // CPU is in. Waiting for a step is "none of the others".
    typedef struct {
        int     rem;
        bit     running;
        bit     exec;
        bit     done;
        longint count;
        int     cause;
        bit     prev;
    } mdl_t;

    mdl_t m1, m2;

    function automatic void mdl_step(inout mdl_t m, input longint max_c, input longint cap,
                                     input bit rst_in, restart, step_mode, step_req, halt_req);
        bit en;
        if (!rst_in) begin
            m.rem = 6; m.running = 0; m.exec = 0; m.done = 0;
            m.count = 0; m.cause = 0; m.prev = 0;
            return;
        end
        en = (m.rem == 0) && (m.running || m.exec);
        if (en) m.count = (m.count < cap) ? m.count + 1 : cap;
        if (restart) begin
            m.rem = 6; m.running = 0; m.exec = 0; m.done = 0; m.count = 0; m.cause = 0;
        end else if (en && halt_req) begin
            m.running = 0; m.exec = 0; m.done = 1; m.cause = 1;
        end else if (en && max_c != 0 && m.count == max_c) begin
            m.running = 0; m.exec = 0; m.done = 1; m.cause = 2;
        end else if (m.rem > 0) begin
            m.rem--;
            if (m.rem == 0) m.running = !step_mode;
        end else if (m.running) begin
            if (step_mode) m.running = 0;
        end else if (m.exec) begin
            m.exec = 0;
        end else if (!m.done) begin
            if (!step_mode)                    m.running = 1;
            else if (step_req && !m.prev)      m.exec = 1;
        end
        m.prev = step_req;
    endfunction

    function automatic void cmp(input string nm, input mdl_t m, input logic c_rst, c_en, c_done,
                                input logic [63:0] cnt, input logic [1:0] cause, input logic [2:0] st);
        logic [2:0] e_st;
        logic       e_rst, e_en;
        e_st  = (m.rem > 0) ? 3'd0 : m.running ? 3'd1 : m.exec ? 3'd3 : m.done ? 3'd4 : 3'd2;
        e_rst = (m.rem == 0);
        e_en  = (m.rem == 0) && (m.running || m.exec);
        n_vec++;
        if (c_rst !== e_rst || c_en !== e_en || c_done !== m.done || cnt !== 64'(m.count) ||
            cause !== 2'(m.cause) || st !== e_st) begin
            n_err++;
            $display("FAIL %s t=%0t got rst=%b en=%b done=%b cnt=%0d cause=%0d st=%0d want rst=%b en=%b done=%b cnt=%0d cause=%0d st=%0d",
                     nm, $time, c_rst, c_en, c_done, cnt, cause, st,
                     e_rst, e_en, m.done, m.count, m.cause, e_st);
        end
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        mdl_step(m1, 50, 64'hFFFF_FFFF, rst_n, if1.restart, if1.step_mode, if1.step_req, if1.halt_req);
        mdl_step(m2, 0, 15, rst_n, if2.restart, if2.step_mode, if2.step_req, if2.halt_req);
        #1;
        cmp("model_dut1", m1, if1.cpu_rst, if1.cpu_en, if1.done, 64'(if1.cycle_count), if1.halt_cause, if1.state);
        cmp("model_dut2", m2, if2.cpu_rst, if2.cpu_en, if2.done, 64'(if2.cycle_count), if2.halt_cause, if2.state);
    endtask

    // Runs from the edge after a release/restart until DONE.
    task automatic run_phase(output int rise_at, output int en_first, output int en_cycles);
        rise_at = -1; en_first = -1; en_cycles = 0;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (if1.cpu_rst === 1'b1 && rise_at < 0) rise_at = k;
            if (if1.cpu_en === 1'b1) begin
                en_cycles++;
                if (en_first < 0) en_first = k;
            end
            if (if1.done === 1'b1) break;
        end
    endtask

    task automatic start_run(input bit sm);
        if1.step_mode = sm;
        if1.restart = 1'b1;
        tick();
        if1.restart = 1'b0;
    endtask

    task automatic run_until_count(input int n);
        for (int k = 0; k < 300 && if1.cycle_count != 32'(n); k++) tick();
        chk("reach_count", 64'(if1.cycle_count), 64'(n));
    endtask

    typedef struct {
        bit       rst_n, restart, sm, sr, halt;
        bit [2:0] e_st;
        bit       e_rst, e_en;
        int       e_cnt;
    } vec_t;

    function automatic vec_t mk(bit r, rs, sm, sr, h, bit [2:0] st, bit er, ee, int ec);
        vec_t v;
        v.rst_n = r; v.restart = rs; v.sm = sm; v.sr = sr; v.halt = h;
        v.e_st = st; v.e_rst = er; v.e_en = ee; v.e_cnt = ec;
        return v;
    endfunction

    initial begin
        vec_t tbl[21];
        int   rise_a, enf_a, en_a, rise_b, enf_b, en_b;

        rst_n = 1'b0;
        if1.restart = 0; if1.step_mode = 0; if1.step_req = 0; if1.halt_req = 0;
        if2.restart = 0; if2.step_mode = 0; if2.step_req = 0; if2.halt_req = 0;

        // Step-mode bring-up, held step, halt ignored, mode switch on a step
        // edge, run->step, restart.
        for (int i = 0; i < 5; i++)  tbl[i] = mk(0, 0, 1, 0, 0, 3'd0, 0, 0, 0);
        for (int i = 5; i < 10; i++) tbl[i] = mk(1, 0, 1, 0, 0, 3'd0, 0, 0, 0);
        tbl[10] = mk(1, 0, 1, 0, 0, 3'd2, 1, 0, 0);
        tbl[11] = mk(1, 0, 1, 1, 0, 3'd3, 1, 1, 0);
        tbl[12] = mk(1, 0, 1, 1, 0, 3'd2, 1, 0, 1);
        tbl[13] = mk(1, 0, 1, 1, 0, 3'd2, 1, 0, 1);
        tbl[14] = mk(1, 0, 1, 0, 1, 3'd2, 1, 0, 1);
        tbl[15] = mk(1, 0, 1, 1, 0, 3'd3, 1, 1, 1);
        tbl[16] = mk(1, 0, 1, 0, 0, 3'd2, 1, 0, 2);
        tbl[17] = mk(1, 0, 0, 1, 0, 3'd1, 1, 1, 2);
        tbl[18] = mk(1, 0, 0, 0, 0, 3'd1, 1, 1, 3);
        tbl[19] = mk(1, 0, 1, 0, 0, 3'd2, 1, 0, 4);
        tbl[20] = mk(1, 1, 1, 0, 0, 3'd0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            rst_n = tbl[i].rst_n; if1.restart = tbl[i].restart; if1.step_mode = tbl[i].sm;
            if1.step_req = tbl[i].sr; if1.halt_req = tbl[i].halt;
            tick();
            chk("tbl_state",  64'(if1.state),       64'(tbl[i].e_st));
            chk("tbl_cpurst", 64'(if1.cpu_rst),     64'(tbl[i].e_rst));
            chk("tbl_cpuen",  64'(if1.cpu_en),      64'(tbl[i].e_en));
            chk("tbl_count",  64'(if1.cycle_count), 64'(tbl[i].e_cnt));
        end
        if1.restart = 0; if1.step_mode = 0; if1.step_req = 0; if1.halt_req = 0;

        // Free run from reset to the cycle limit.
        rst_n = 1'b0;
        repeat (5) tick();
        chk("reset_done",  64'(if1.done),       64'd0);
        chk("reset_cause", 64'(if1.halt_cause), 64'd0);
        rst_n = 1'b1;
        run_phase(rise_a, enf_a, en_a);
        chk("rise_edge",   64'(rise_a), 64'd6);
        chk("en_rise",     64'(enf_a),  64'd6);
        chk("en_cycles",   64'(en_a),   64'd50);
        chk("lim_done",    64'(if1.done), 64'd1);
        chk("lim_cause",   64'(if1.halt_cause), 64'd2);
        chk("lim_count",   64'(if1.cycle_count), 64'd50);
        chk("lim_state",   64'(if1.state), 64'd4);
        repeat (3) tick();
        chk("done_stable", 64'(if1.cycle_count), 64'd50);

        // Unlimited, 4-bit counter: saturates and never stops.
        chk("sat_count", 64'(if2.cycle_count), 64'd15);
        chk("sat_done",  64'(if2.done), 64'd0);
        chk("sat_state", 64'(if2.state), 64'd1);

        // Restart from DONE repeats the run identically.
        if1.restart = 1'b1;
        tick();
        if1.restart = 1'b0;
        chk("rs_count",  64'(if1.cycle_count), 64'd0);
        chk("rs_cpurst", 64'(if1.cpu_rst), 64'd0);
        chk("rs_cause",  64'(if1.halt_cause), 64'd0);
        run_phase(rise_b, enf_b, en_b);
        chk("rs_rise",   64'(rise_b), 64'd6);
        chk("rs_enc",    64'(en_b),   64'd50);
        chk("rs_cause2", 64'(if1.halt_cause), 64'd2);

        // Halt at enabled cycle 20.
        start_run(1'b0);
        run_until_count(19);
        if1.halt_req = 1'b1;
        tick();
        if1.halt_req = 1'b0;
        chk("halt_count", 64'(if1.cycle_count), 64'd20);
        chk("halt_cause", 64'(if1.halt_cause), 64'd1);
        chk("halt_state", 64'(if1.state), 64'd4);

        // Halt coincident with the limit.
        start_run(1'b0);
        run_until_count(49);
        if1.halt_req = 1'b1;
        tick();
        if1.halt_req = 1'b0;
        chk("both_cause", 64'(if1.halt_cause), 64'd1);
        chk("both_count", 64'(if1.cycle_count), 64'd50);

        // rst in the middle of STEP_EXEC.
        start_run(1'b1);
        for (int k = 0; k < 20 && if1.state != 3'd2; k++) tick();
        if1.step_req = 1'b1; tick();
        if1.step_req = 1'b0; tick();
        if1.step_req = 1'b1; tick();
        chk("pre_exec", 64'(if1.state), 64'd3);
        rst_n = 1'b0;
        tick();
        chk("mid_state", 64'(if1.state), 64'd0);
        chk("mid_en",    64'(if1.cpu_en), 64'd0);
        chk("mid_rst",   64'(if1.cpu_rst), 64'd0);
        chk("mid_count", 64'(if1.cycle_count), 64'd0);
        chk("mid_done",  64'(if1.done), 64'd0);
        if1.step_req = 1'b0;
        rst_n = 1'b1;

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            if1.restart   = ($urandom_range(0, 59) == 0);
            if2.restart   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) if1.step_mode = ~if1.step_mode;
            if ($urandom_range(0, 29) == 0) if2.step_mode = ~if2.step_mode;
            if1.step_req  = ($urandom_range(0, 2) == 0);
            if2.step_req  = ($urandom_range(0, 2) == 0);
            if1.halt_req  = ($urandom_range(0, 39) == 0);
            if2.halt_req  = ($urandom_range(0, 79) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
